// File: rtl/cus4x_pkg.sv
// Shared definitions for the CUS42 tile fetcher and the CUS43 slice interface.
// Register map, bus widths, fetch phases and the 3-plane slice layout.
package cus4x_pkg;

  localparam int VA_W = 13;
  localparam int GA_W = 14;
  localparam int GD_W = 12;

  localparam logic [2:0] REG_A_SX_L = 3'd0;
  localparam logic [2:0] REG_A_SX_H = 3'd1;
  localparam logic [2:0] REG_A_SY   = 3'd2;
  localparam logic [2:0] REG_B_SX_L = 3'd4;
  localparam logic [2:0] REG_B_SX_H = 3'd5;
  localparam logic [2:0] REG_B_SY   = 3'd6;

  localparam logic [2:0] PH_A_CODE = 3'd0;
  localparam logic [2:0] PH_A_ATTR = 3'd1;
  localparam logic [2:0] PH_A_ROM  = 3'd2;
  localparam logic [2:0] PH_A_OUT  = 3'd3;
  localparam logic [2:0] PH_B_CODE = 3'd4;
  localparam logic [2:0] PH_B_ATTR = 3'd5;
  localparam logic [2:0] PH_B_ROM  = 3'd6;
  localparam logic [2:0] PH_B_OUT  = 3'd7;

  typedef struct packed {
    logic [3:0] p2;
    logic [3:0] p1;
    logic [3:0] p0;
  } slice_t;

  function automatic logic [3:0] rev4(input logic [3:0] n);
    return {n[0], n[1], n[2], n[3]};
  endfunction

  function automatic slice_t slice_rev(input slice_t s);
    slice_t r;
    r.p2 = rev4(s.p2);
    r.p1 = rev4(s.p1);
    r.p0 = rev4(s.p0);
    return r;
  endfunction

endpackage

// File: rtl/cus42_layer_addr.sv
// Per-layer scroll arithmetic and VRAM/ROM address packing.
// Screen flip inversion exists only when CUS42_FLIP_EN is defined.
module cus42_layer_addr
  import cus4x_pkg::*;
#(
  parameter int LOOKAHEAD = 8
) (
  input  logic            layer,
  input  logic [8:0]      sx,
  input  logic [7:0]      sy,
  input  logic [8:0]      hcnt,
  input  logic [7:0]      vpos,
  input  logic            flip,
  input  logic [7:0]      code,
  input  logic [1:0]      pal,
  output logic [VA_W-1:0] va_code,
  output logic [VA_W-1:0] va_attr,
  output logic [GA_W-1:0] ga
);

  logic [8:0] ex;
  logic [7:0] ey;
  logic [8:0] exu;
  logic [7:0] eyu;
  logic       unused_lo;

  assign ex = hcnt + 9'(LOOKAHEAD) + sx;
  assign ey = vpos + sy;

`ifdef CUS42_FLIP_EN
  assign exu = flip ? ~ex : ex;
  assign eyu = flip ? ~ey : ey;
`else
  logic unused_flip;
  assign unused_flip = flip;
  assign exu = ex;
  assign eyu = ey;
`endif

  // Low ex bits only select pixels within a half-tile row.
  assign unused_lo = &{1'b0, exu[1:0]};

  assign va_code = {layer, eyu[7:3], exu[8:3], 1'b0};
  assign va_attr = {layer, eyu[7:3], exu[8:3], 1'b1};
  assign ga      = {pal, code, eyu[2:0], exu[2]};

endmodule

// File: rtl/cus42_tile_fetch.sv
// Tilemap fetch sequencer feeding CUS43 (GDI/MDI/HA2/HB2 producer side).
// Define CUS42_FLIP_EN to build screen-flip address inversion and slice reversal.
module cus42_tile_fetch
  import cus4x_pkg::*;
#(
  parameter int VRAM_LAT  = 1,
  parameter int ROM_LAT   = 1,
  parameter int LOOKAHEAD = 8
) (
  input  logic            CLK_6M,
  input  logic            RST_N,
  input  logic            LINE_START,
  input  logic [7:0]      VPOS,
  input  logic            FLIP,
  input  logic            CPU_WE,
  input  logic [2:0]      CPU_A,
  input  logic [7:0]      CPU_D,
  output logic [VA_W-1:0] VA,
  input  logic [7:0]      VD,
  output logic [GA_W-1:0] GA,
  input  logic [GD_W-1:0] GD,
  output logic [GD_W-1:0] GDO,
  output logic [7:0]      MDO,
  output logic            HA2,
  output logic            HB2
);

  if (VRAM_LAT != 1 || ROM_LAT != 1) begin : g_lat_check
    $error("cus42_tile_fetch: only VRAM_LAT=1 and ROM_LAT=1 are supported");
  end

  logic [8:0]      hcnt;
  logic [2:0]      phase;
  logic [8:0]      a_sx, b_sx, sh_a_sx, sh_b_sx;
  logic [7:0]      a_sy, b_sy, sh_a_sy, sh_b_sy;
  logic [7:0]      sh_a_vp, sh_b_vp;
  logic            sh_a_fl, sh_b_fl;
  logic [7:0]      code, attr;
  logic [GD_W-1:0] gdo_q;
  logic [7:0]      mdo_q;
  logic [GD_W-1:0] gd_x;
  logic            a_now, b_now, strobe;

  logic [8:0]      a_sx_u, b_sx_u;
  logic [7:0]      a_sy_u, b_sy_u, a_vp_u, b_vp_u;
  logic            a_fl_u, b_fl_u;
  logic [VA_W-1:0] a_va_code, a_va_attr, b_va_code, b_va_attr;
  logic [GA_W-1:0] a_ga, b_ga;

  assign phase  = hcnt[2:0];
  assign a_now  = (phase == PH_A_CODE);
  assign b_now  = (phase == PH_B_CODE);
  assign HA2    = (phase == PH_A_OUT);
  assign HB2    = (phase == PH_B_OUT);
  assign strobe = HA2 | HB2;

  // The slot's first cycle sees the live registers; the shadows cover the rest.
  assign a_sx_u = a_now ? a_sx : sh_a_sx;
  assign a_sy_u = a_now ? a_sy : sh_a_sy;
  assign a_vp_u = a_now ? VPOS : sh_a_vp;
  assign a_fl_u = a_now ? FLIP : sh_a_fl;
  assign b_sx_u = b_now ? b_sx : sh_b_sx;
  assign b_sy_u = b_now ? b_sy : sh_b_sy;
  assign b_vp_u = b_now ? VPOS : sh_b_vp;
  assign b_fl_u = b_now ? FLIP : sh_b_fl;

  cus42_layer_addr #(.LOOKAHEAD(LOOKAHEAD)) u_a (
    .layer   (1'b0),
    .sx      (a_sx_u),
    .sy      (a_sy_u),
    .hcnt    ({hcnt[8:3], 3'd0}),
    .vpos    (a_vp_u),
    .flip    (a_fl_u),
    .code    (code),
    .pal     (VD[1:0]),
    .va_code (a_va_code),
    .va_attr (a_va_attr),
    .ga      (a_ga)
  );

  cus42_layer_addr #(.LOOKAHEAD(LOOKAHEAD)) u_b (
    .layer   (1'b1),
    .sx      (b_sx_u),
    .sy      (b_sy_u),
    .hcnt    ({hcnt[8:3], 3'd4}),
    .vpos    (b_vp_u),
    .flip    (b_fl_u),
    .code    (code),
    .pal     (VD[1:0]),
    .va_code (b_va_code),
    .va_attr (b_va_attr),
    .ga      (b_ga)
  );

`ifdef CUS42_FLIP_EN
  logic out_fl;
  assign out_fl = (phase == PH_B_OUT) ? sh_b_fl : sh_a_fl;
  assign gd_x   = out_fl ? slice_rev(slice_t'(GD)) : GD;
`else
  assign gd_x = GD;
`endif

  // The strobe cycle passes the ROM slice straight through; the copy holds it.
  assign GDO = strobe ? gd_x : gdo_q;
  assign MDO = strobe ? attr : mdo_q;

  always_ff @(posedge CLK_6M) begin
    if (!RST_N) begin
      hcnt    <= '0;
      a_sx    <= '0;
      b_sx    <= '0;
      a_sy    <= '0;
      b_sy    <= '0;
      sh_a_sx <= '0;
      sh_b_sx <= '0;
      sh_a_sy <= '0;
      sh_b_sy <= '0;
      sh_a_vp <= '0;
      sh_b_vp <= '0;
      sh_a_fl <= 1'b0;
      sh_b_fl <= 1'b0;
      code    <= '0;
      attr    <= '0;
      VA      <= '0;
      GA      <= '0;
      gdo_q   <= '0;
      mdo_q   <= '0;
    end else begin
      hcnt <= LINE_START ? 9'd0 : hcnt + 9'd1;

      if (CPU_WE) begin
        unique case (CPU_A)
          REG_A_SX_L: a_sx[7:0] <= CPU_D;
          REG_A_SX_H: a_sx[8]   <= CPU_D[0];
          REG_A_SY:   a_sy      <= CPU_D;
          REG_B_SX_L: b_sx[7:0] <= CPU_D;
          REG_B_SX_H: b_sx[8]   <= CPU_D[0];
          REG_B_SY:   b_sy      <= CPU_D;
          default: ;
        endcase
      end

      if (strobe) begin
        gdo_q <= gd_x;
        mdo_q <= attr;
      end

      // A new line abandons whatever slot is in flight.
      if (!LINE_START) begin
        unique case (phase)
          PH_A_CODE: begin
            sh_a_sx <= a_sx;
            sh_a_sy <= a_sy;
            sh_a_vp <= VPOS;
            sh_a_fl <= FLIP;
            VA      <= a_va_code;
          end
          PH_A_ATTR: begin
            code <= VD;
            VA   <= a_va_attr;
          end
          PH_A_ROM: begin
            attr <= VD;
            GA   <= a_ga;
          end
          PH_B_CODE: begin
            sh_b_sx <= b_sx;
            sh_b_sy <= b_sy;
            sh_b_vp <= VPOS;
            sh_b_fl <= FLIP;
            VA      <= b_va_code;
          end
          PH_B_ATTR: begin
            code <= VD;
            VA   <= b_va_attr;
          end
          PH_B_ROM: begin
            attr <= VD;
            GA   <= b_ga;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cus42_tile_fetch.sv
// Bench for cus42_tile_fetch: slot-level model with VRAM/ROM arrays,
// per-cycle comparison, plus hand-computed directed expectations.
module tb_cus42_tile_fetch;

  logic        clk = 1'b0;
  logic        RST_N, LINE_START, FLIP, CPU_WE;
  logic [7:0]  VPOS, CPU_D, VD, MDO;
  logic [2:0]  CPU_A;
  logic [12:0] VA;
  logic [13:0] GA;
  logic [11:0] GD, GDO;
  logic        HA2, HB2;

  logic [7:0]  vram [0:8191];
  logic [11:0] rom  [0:16383];

  always #5 clk = ~clk;

  assign VD = vram[VA];
  assign GD = rom[GA];

  cus42_tile_fetch dut (
    .CLK_6M     (clk),
    .RST_N      (RST_N),
    .LINE_START (LINE_START),
    .VPOS       (VPOS),
    .FLIP       (FLIP),
    .CPU_WE     (CPU_WE),
    .CPU_A      (CPU_A),
    .CPU_D      (CPU_D),
    .VA         (VA),
    .VD         (VD),
    .GA         (GA),
    .GD         (GD),
    .GDO        (GDO),
    .MDO        (MDO),
    .HA2        (HA2),
    .HB2        (HB2)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int rev4(input int n);
    return ((n & 1) << 3) | ((n & 2) << 1) | ((n & 4) >> 1) | ((n & 8) >> 3);
  endfunction

  // Model: each slot is resolved whole at its first cycle from the scroll
  // registers and memory contents; later cycles just expose its pieces.
  int mh;
  int m_sx [2];
  int m_sy [2];
  int s_ca [2];
  int s_ga [2];
  int s_gdo [2];
  int s_attr [2];
  int e_va, e_ga, e_gdo, e_mdo;
  bit model_ok = 1'b0;

  always @(posedge clk) begin : model
    int ph, l, ex, ey, cd, g, d;
    bit fl;
    if (!RST_N) begin
      mh = 0;
      for (int i = 0; i < 2; i++) begin
        m_sx[i] = 0; m_sy[i] = 0; s_ca[i] = 0;
        s_ga[i] = 0; s_gdo[i] = 0; s_attr[i] = 0;
      end
      e_va = 0; e_ga = 0; e_gdo = 0; e_mdo = 0;
      model_ok = 1'b1;
    end else begin
      ph = mh % 8;
      l = ph / 4;
      if (ph % 4 == 3) begin
        e_gdo = s_gdo[l];
        e_mdo = s_attr[l];
      end
      if (!LINE_START) begin
        if (ph % 4 == 0) begin
          ex = (mh + 8 + m_sx[l]) % 512;
          ey = (int'(VPOS) + m_sy[l]) % 256;
`ifdef CUS42_FLIP_EN
          fl = FLIP;
`else
          fl = 1'b0;
`endif
          if (fl) begin
            ex = 511 - ex;
            ey = 255 - ey;
          end
          s_ca[l] = l * 4096 + (ey / 8) * 128 + (ex / 8) * 2;
          cd = int'(vram[s_ca[l]]);
          s_attr[l] = int'(vram[s_ca[l] + 1]);
          g = (s_attr[l] % 4) * 4096 + cd * 16 + (ey % 8) * 2 + (ex / 4) % 2;
          s_ga[l] = g;
          d = int'(rom[g]);
          if (fl)
            d = (rev4((d >> 8) & 15) << 8) | (rev4((d >> 4) & 15) << 4)
                | rev4(d & 15);
          s_gdo[l] = d;
          e_va = s_ca[l];
        end else if (ph % 4 == 1) begin
          e_va = s_ca[l] + 1;
        end else if (ph % 4 == 2) begin
          e_ga = s_ga[l];
        end
      end
      if (CPU_WE) begin
        case (CPU_A)
          3'd0: m_sx[0] = (m_sx[0] & 256) | int'(CPU_D);
          3'd1: m_sx[0] = (m_sx[0] & 255) | (int'(CPU_D[0]) << 8);
          3'd2: m_sy[0] = int'(CPU_D);
          3'd4: m_sx[1] = (m_sx[1] & 256) | int'(CPU_D);
          3'd5: m_sx[1] = (m_sx[1] & 255) | (int'(CPU_D[0]) << 8);
          3'd6: m_sy[1] = int'(CPU_D);
          default: ;
        endcase
      end
      mh = LINE_START ? 0 : (mh + 1) % 512;
    end
  end

  always @(negedge clk) begin : compare
    int ph;
    if (model_ok) begin
      ph = mh % 8;
      chk("va", 32'(VA), e_va);
      chk("ga", 32'(GA), e_ga);
      chk("ha2", 32'(HA2), (ph == 3) ? 1 : 0);
      chk("hb2", 32'(HB2), (ph == 7) ? 1 : 0);
      chk("gdo", 32'(GDO), (ph % 4 == 3) ? s_gdo[ph / 4] : e_gdo);
      chk("mdo", 32'(MDO), (ph % 4 == 3) ? s_attr[ph / 4] : e_mdo);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic ls_pulse();
    LINE_START = 1'b1;
    step(1);
    LINE_START = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    CPU_WE = 1'b1;
    CPU_A  = a;
    CPU_D  = d;
    step(1);
    CPU_WE = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) vram[i] = 8'((i * 37 + 11) ^ (i >> 5));
    for (int i = 0; i < 16384; i++) rom[i] = 12'((i * 13) ^ (i >> 3));
    vram[2]     = 8'h5A;
    vram[3]     = 8'h03;
    vram[12'hFFC] = 8'h5A;
    vram[12'hFFD] = 8'h03;
    rom[14'h35A0] = 12'h821;
    rom[14'h35AF] = 12'h821;

    // Reset asserted together with a line start and a register write.
    RST_N = 1'b0; LINE_START = 1'b1; FLIP = 1'b0; VPOS = 8'd0;
    CPU_WE = 1'b1; CPU_A = 3'd0; CPU_D = 8'hFF;
    step(3);
    chk("rst_va", 32'(VA), 0);
    chk("rst_ga", 32'(GA), 0);
    chk("rst_gdo", 32'(GDO), 0);
    chk("rst_mdo", 32'(MDO), 0);
    chk("rst_ha2", 32'(HA2), 0);
    chk("rst_hb2", 32'(HB2), 0);
    RST_N = 1'b1; LINE_START = 1'b0; CPU_WE = 1'b0;
    step(5);

    // Zero scroll: ex=8 gives code address 0x0002.
    ls_pulse();
    step(1);
    chk("t1_va", 32'(VA), 32'h0002);
    step(2);
    chk("t1_ha2", 32'(HA2), 1);
    chk("t1_hb2_lo", 32'(HB2), 0);
    chk("t2_ga", 32'(GA), 32'h35A0);
    chk("t2_mdo", 32'(MDO), 32'h03);
    chk("t2_gdo", 32'(GDO), 32'h821);
    step(4);
    chk("t1_hb2", 32'(HB2), 1);
    chk("t1_ha2_lo", 32'(HA2), 0);
    step(4);
    chk("t1_ha2_again", 32'(HA2), 1);

    // Horizontal scroll wrap: ex = 0 + 8 + 0x1F8 = 0x200 -> 0.
    wr(3'd0, 8'hF8);
    wr(3'd1, 8'h01);
    ls_pulse();
    step(1);
    chk("t3_va_ex", 32'(VA[6:1]), 0);
    chk("t3_va", 32'(VA), 32'h0000);

    // SY write in the slot-A sample cycle (hcnt 8).
    step(7);
    CPU_WE = 1'b1; CPU_A = 3'd2; CPU_D = 8'h10;
    step(1);
    CPU_WE = 1'b0;
    chk("t4_old_sy", 32'(VA), 32'h0002);
    step(8);
    chk("t4_new_sy", 32'(VA), 32'h0104);

    // Line start at phase 2 abandons the slot.
    step(1);
    LINE_START = 1'b1;
    step(1);
    LINE_START = 1'b0;
    chk("t5_no_ha2", 32'(HA2), 0);
    chk("t5_va_hold", 32'(VA), 32'h0105);
    step(1);
    chk("t5_va_new", 32'(VA), 32'h0100);
    step(1);
    chk("t5_no_ha2_p2", 32'(HA2), 0);
    step(1);
    chk("t5_ha2", 32'(HA2), 1);

    // Line start during a strobe: strobe still present that cycle.
    LINE_START = 1'b1;
    #1;
    chk("ls_strobe_ha2", 32'(HA2), 1);
    step(1);
    LINE_START = 1'b0;
    chk("ls_strobe_next", 32'(HA2), 0);

    // Directed sweep of register writes, vpos, flip and line starts.
    for (int i = 0; i < 600; i++) begin
      CPU_WE     = (i % 5 == 0);
      CPU_A      = 3'((i * 3) % 8);
      CPU_D      = 8'(i * 29 + 7);
      LINE_START = (i % 53 == 17) || (i % 97 == 42);
      VPOS       = 8'((i / 16) * 7);
      FLIP       = (i % 64 >= 40);
      step(1);
    end
    CPU_WE = 1'b0; LINE_START = 1'b0; FLIP = 1'b0;
    step(4);

`ifdef CUS42_FLIP_EN
    wr(3'd0, 8'h00); wr(3'd1, 8'h00); wr(3'd2, 8'h00);
    VPOS = 8'd0;
    FLIP = 1'b1;
    ls_pulse();
    step(3);
    chk("t6_ga", 32'(GA), 32'h35AF);
    chk("t6_ga_row", 32'(GA[3:1]), 7);
    chk("t6_gdo", 32'(GDO), 32'h148);
    FLIP = 1'b0;
    step(8);
`endif

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
